// File: rtl/bcd_seg_display.sv
// Captures a 4-bit sum over valid/ready, splits it into tens/ones BCD digits and
// drives a two-digit time-multiplexed 7-segment display with leading-zero blanking.
module bcd_seg_display #(
    parameter int unsigned REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic [3:0] held,
    output logic [1:0] an,
    output logic [6:0] seg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        SHOW    = 2'd2
    } state_t;

    localparam logic [15:0] LAST_COUNT = 16'(REFRESH_DIV - 1);

    state_t      state_q;
    logic [3:0]  held_q;
    logic        tens_q;
    logic [3:0]  ones_q;
    logic [15:0] refreshCnt_q;
    logic        digitSel_q;
    logic        capture;
    logic [6:0]  onesPattern;

    assign in_ready = (state_q != CONVERT);
    assign capture  = in_valid && in_ready;
    assign held     = held_q;

    // A capture from IDLE or SHOW always wins and restarts conversion; the
    // refresh slot timing only advances while nothing new arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            held_q       <= 4'd0;
            tens_q       <= 1'b0;
            ones_q       <= 4'd0;
            refreshCnt_q <= 16'd0;
            digitSel_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        held_q  <= in_data;
                        state_q <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (held_q >= 4'd10) begin
                        tens_q <= 1'b1;
                        ones_q <= held_q - 4'd10;
                    end else begin
                        tens_q <= 1'b0;
                        ones_q <= held_q;
                    end
                    refreshCnt_q <= 16'd0;
                    digitSel_q   <= 1'b0;
                    state_q      <= SHOW;
                end
                SHOW: begin
                    if (capture) begin
                        held_q  <= in_data;
                        state_q <= CONVERT;
                    end else if (refreshCnt_q == LAST_COUNT) begin
                        refreshCnt_q <= 16'd0;
                        digitSel_q   <= ~digitSel_q;
                    end else begin
                        refreshCnt_q <= refreshCnt_q + 16'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Segment patterns are {g,f,e,d,c,b,a}, active high.
    always_comb begin
        onesPattern = 7'h00;
        case (ones_q)
            4'd0:    onesPattern = 7'h3F;
            4'd1:    onesPattern = 7'h06;
            4'd2:    onesPattern = 7'h5B;
            4'd3:    onesPattern = 7'h4F;
            4'd4:    onesPattern = 7'h66;
            4'd5:    onesPattern = 7'h6D;
            4'd6:    onesPattern = 7'h7D;
            4'd7:    onesPattern = 7'h07;
            4'd8:    onesPattern = 7'h7F;
            4'd9:    onesPattern = 7'h6F;
            default: onesPattern = 7'h00;
        endcase
    end

    always_comb begin
        an  = 2'b00;
        seg = 7'h00;
        if (state_q == SHOW) begin
            if (!digitSel_q) begin
                an  = 2'b01;
                seg = onesPattern;
            end else if (tens_q) begin
                an  = 2'b10;
                seg = 7'h06;
            end
        end
    end

endmodule
